// File: rtl/shift_execute_unit.sv
// shift_execute_unit
// Two-stage pipelined shift unit (SLL, SRL, SRA, ROL) for 32-bit operands.
// Every shift is built from a 32-bit left shifter:
//   right shifts reverse the operand, shift it left, then reverse the result;
//   rotates OR a left shift with a reversed left shift of (32 - amount).
// Uses valid/ready on both sides. flush kills all in-flight ops.
module shift_execute_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [4:0]  in_amount,
   input  logic [4:0]  in_rd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [4:0]  out_rd
);

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROL = 2'b11
   } op_e;

   function automatic logic [31:0] reverse32(input logic [31:0] x);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i] = x[31-i];
      end
      return r;
   endfunction

   // Left shift that shifts in 'fill' instead of zeros at the bottom.
   function automatic logic [31:0] shl32(input logic [31:0] x,
                                         input logic [4:0]  s,
                                         input logic        fill);
      logic [31:0] fill_mask;
      fill_mask = fill ? ~(32'hFFFF_FFFF << s) : 32'h0;
      return (x << s) | fill_mask;
   endfunction

   // Stage S1
   logic        v1;
   op_e         op1;
   logic [31:0] a1;
   logic [31:0] rev1;
   logic [4:0]  amt1;
   logic [4:0]  rd1;
   logic        fill1;

   // Stage S2
   logic        v2;
   logic [31:0] result2;
   logic [4:0]  rd2;

   logic        s1_load;
   logic        s2_load;
   logic [31:0] sh_main_in;
   logic [31:0] sh_main;
   logic [4:0]  rot_amt;
   logic [31:0] sh_rot;
   logic [31:0] s1_result;

   assign s2_load    = !v2 || out_ready;
   assign s1_load    = !v1 || s2_load;
   assign in_ready   = s1_load;
   assign out_valid  = v2;
   assign out_result = result2;
   assign out_rd     = rd2;

   // Shared datapath: the main shifter serves all four ops, the second only rotates.
   always_comb begin
      sh_main_in = ((op1 == OP_SLL) || (op1 == OP_ROL)) ? a1 : rev1;
      sh_main    = shl32(sh_main_in, amt1, fill1);
      rot_amt    = 5'd0 - amt1;
      sh_rot     = shl32(rev1, rot_amt, 1'b0);
      s1_result  = '0;
      case (op1)
         OP_SLL:  s1_result = sh_main;
         OP_SRL:  s1_result = reverse32(sh_main);
         OP_SRA:  s1_result = reverse32(sh_main);
         OP_ROL:  s1_result = sh_main | ((amt1 == 5'd0) ? 32'h0 : reverse32(sh_rot));
         default: s1_result = '0;
      endcase
   end

   // Pipeline registers; reset over flush, flush over any load.
   always_ff @(posedge clk) begin
      if (reset) begin
         v1      <= 1'b0;
         op1     <= OP_SLL;
         a1      <= '0;
         rev1    <= '0;
         amt1    <= '0;
         rd1     <= '0;
         fill1   <= 1'b0;
         v2      <= 1'b0;
         result2 <= '0;
         rd2     <= '0;
      end else if (flush) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         if (s2_load) begin
            v2 <= v1;
            if (v1) begin
               result2 <= s1_result;
               rd2     <= rd1;
            end
         end
         if (s1_load) begin
            v1 <= in_valid;
            if (in_valid) begin
               op1   <= op_e'(in_op);
               a1    <= in_a;
               rev1  <= reverse32(in_a);
               amt1  <= in_amount;
               rd1   <= in_rd;
               fill1 <= (in_op == 2'b10) && in_a[31];
            end
         end
      end
   end

endmodule

// File: tb/tb_shift_execute_unit.sv
// Scoreboard bench for shift_execute_unit: a logger queues the expected result of
// every accepted op, and a monitor pops and compares on every output handshake.
module tb_shift_execute_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_op = 2'b00;
   logic [31:0] in_a = '0;
   logic [4:0]  in_amount = '0;
   logic [4:0]  in_rd = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_result;
   logic [4:0]  out_rd;

   always #5 clk = ~clk;

   shift_execute_unit dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_amount  (in_amount),
      .in_rd      (in_rd),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_rd     (out_rd)
   );

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   logic [31:0] exp_cur = '0;
   logic        check_lat = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;

   int to_cnt = 0;
   int to_seen = 0;

   int          chk_seq = 0;
   int          chk_done = 0;
   int          chk_mode = 0;
   string       chk_name = "";
   logic        chk_vld = 1'b0;
   logic        chk_rdy = 1'b0;
   logic [31:0] chk_res = '0;
   logic [4:0]  chk_rd = '0;

   logic        hold_prev = 1'b0;
   logic [31:0] hold_res = '0;
   logic [4:0]  hold_rd = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model written with native shift/rotate operators.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [4:0] amt);
      case (op)
         2'b00:   return a << amt;
         2'b01:   return a >> amt;
         2'b10:   return $unsigned($signed(a) >>> amt);
         default: return (amt == 5'd0) ? a : ((a << amt) | (a >> (32 - int'(amt))));
      endcase
   endfunction

   // Logger: record accepted ops; reset or flush discards everything still in flight.
   always @(negedge clk) begin
      #1;
      if (reset || flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{exp_cur, in_rd, cyc});
   end

   // Monitor: all comparisons happen here.
   always @(negedge clk) begin
      exp_t e;
      if (hold_prev) begin
         n_cmp++;
         if (!out_valid || out_result !== hold_res || out_rd !== hold_rd) begin
            n_bad++;
            $display("FAIL hold_stable: got vld=%0b res=%h rd=%0d, want vld=1 res=%h rd=%0d",
                     out_valid, out_result, out_rd, hold_res, hold_rd);
         end
      end
      hold_prev = (out_valid === 1'b1) && !out_ready && !flush && !reset;
      hold_res  = out_result;
      hold_rd   = out_rd;

      if (out_valid === 1'b1 && out_ready && !reset) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output: got res=%h rd=%0d, want no output", out_result, out_rd);
         end else begin
            e = sb.pop_front();
            if (out_result !== e.res || out_rd !== e.rd) begin
               n_bad++;
               $display("FAIL result: got res=%h rd=%0d, want res=%h rd=%0d",
                        out_result, out_rd, e.res, e.rd);
            end
            if (check_lat) begin
               n_cmp++;
               if (cyc - e.cyc != 2) begin
                  n_bad++;
                  $display("FAIL latency: got %0d cycles, want 2", cyc - e.cyc);
               end
            end
         end
      end

      if (to_cnt != to_seen) begin
         to_seen = to_cnt;
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got no in_ready within 50 cycles, want accept");
      end

      if (chk_seq != chk_done) begin
         chk_done = chk_seq;
         n_cmp++;
         if (chk_mode == 2) begin
            if (sb.size() != 0) begin
               n_bad++;
               $display("FAIL %s: got %0d pending, want 0 pending", chk_name, sb.size());
            end
         end else if (out_valid !== chk_vld || in_ready !== chk_rdy ||
                      (chk_mode == 0 && (out_result !== chk_res || out_rd !== chk_rd))) begin
            n_bad++;
            $display("FAIL %s: got vld=%0b rdy=%0b res=%h rd=%0d, want vld=%0b rdy=%0b res=%h rd=%0d",
                     chk_name, out_valid, in_ready, out_result, out_rd,
                     chk_vld, chk_rdy, chk_res, chk_rd);
         end
      end
   end

   // All driver tasks start and end one time unit after a rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Ask the monitor to check outputs at this cycle's falling edge.
   task automatic req(input string nm, input int mode, input logic v, input logic r,
                      input logic [31:0] res, input logic [4:0] rd);
      chk_name = nm;
      chk_mode = mode;
      chk_vld  = v;
      chk_rdy  = r;
      chk_res  = res;
      chk_rd   = rd;
      chk_seq++;
      step(1);
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [4:0] amt,
                        input logic [4:0] rd, input logic [31:0] exp_res);
      logic ok;
      in_valid  = 1'b1;
      in_op     = op;
      in_a      = a;
      in_amount = amt;
      in_rd     = rd;
      exp_cur   = exp_res;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         #2;
         ok = in_ready;
         step(1);
      end
      if (!ok) to_cnt++;
      in_valid = 1'b0;
   endtask

   initial begin
      // Reset: outputs all zero, in_ready high.
      step(1);
      req("reset_outputs", 0, 1'b0, 1'b1, 32'h0, 5'd0);
      reset = 1'b0;
      req("after_reset", 0, 1'b0, 1'b1, 32'h0, 5'd0);

      // Single SLL with latency check.
      issue(2'b00, 32'h0000_0001, 5'd31, 5'd3, 32'h8000_0000);
      step(4);

      // SRL vs SRA, then rotates including amount boundaries.
      issue(2'b01, 32'hF000_0000, 5'd4, 5'd4, 32'h0F00_0000);
      issue(2'b10, 32'hF000_0000, 5'd4, 5'd5, 32'hFF00_0000);
      issue(2'b01, 32'hF000_0000, 5'd0, 5'd6, 32'hF000_0000);
      issue(2'b10, 32'hF000_0000, 5'd0, 5'd7, 32'hF000_0000);
      issue(2'b11, 32'h8000_0001, 5'd1, 5'd1, 32'h0000_0003);
      issue(2'b11, 32'h8000_0001, 5'd0, 5'd2, 32'h8000_0001);
      issue(2'b11, 32'h8000_0001, 5'd31, 5'd3, 32'hC000_0000);
      step(4);

      // Eight back-to-back ops with out_ready high.
      issue(2'b00, 32'h1234_5678, 5'd4,  5'd8,  32'h2345_6780);
      issue(2'b01, 32'h1234_5678, 5'd8,  5'd9,  32'h0012_3456);
      issue(2'b10, 32'h8000_0000, 5'd31, 5'd10, 32'hFFFF_FFFF);
      issue(2'b11, 32'h1234_5678, 5'd8,  5'd11, 32'h3456_7812);
      issue(2'b00, 32'hFFFF_FFFF, 5'd0,  5'd12, 32'hFFFF_FFFF);
      issue(2'b01, 32'hFFFF_FFFF, 5'd31, 5'd13, 32'h0000_0001);
      issue(2'b10, 32'h7FFF_FFFF, 5'd30, 5'd14, 32'h0000_0001);
      issue(2'b11, 32'h0000_0001, 5'd31, 5'd15, 32'h8000_0000);
      step(4);

      // Backpressure: capacity of two, stable output while stalled.
      check_lat = 1'b0;
      out_ready = 1'b0;
      issue(2'b00, 32'h0000_00A5, 5'd4, 5'd20, 32'h0000_0A50);
      issue(2'b01, 32'h0000_0A50, 5'd4, 5'd21, 32'h0000_00A5);
      req("full_not_ready", 1, 1'b1, 1'b0, 32'h0, 5'd0);
      step(3);
      out_ready = 1'b1;
      issue(2'b11, 32'h0000_000F, 5'd30, 5'd22, 32'hC000_0003);
      issue(2'b10, 32'h8000_0010, 5'd4,  5'd23, 32'hF800_0001);
      step(4);

      // Flush with both stages full and a new op offered.
      out_ready = 1'b0;
      issue(2'b00, 32'h0000_0011, 5'd1, 5'd24, 32'h0000_0022);
      issue(2'b00, 32'h0000_0022, 5'd1, 5'd25, 32'h0000_0044);
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_op     = 2'b01;
      in_a      = 32'hDEAD_BEEF;
      in_amount = 5'd3;
      in_rd     = 5'd26;
      exp_cur   = 32'h1BD5_B7DD;
      step(1);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      req("after_flush", 1, 1'b0, 1'b1, 32'h0, 5'd0);
      step(3);
      check_lat = 1'b1;
      issue(2'b00, 32'h0000_0003, 5'd2, 5'd1, 32'h0000_000C);
      step(4);

      // Random traffic with backpressure, flush and reset.
      check_lat = 1'b0;
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_op     = 2'($urandom_range(0, 3));
         in_a      = $urandom;
         in_amount = 5'($urandom_range(0, 31));
         in_rd     = 5'($urandom_range(0, 31));
         exp_cur   = model(in_op, in_a, in_amount);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 31) == 0);
         reset     = ($urandom_range(0, 63) == 0);
         step(1);
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      reset     = 1'b0;
      out_ready = 1'b1;
      step(5);
      req("drained", 2, 1'b0, 1'b0, 32'h0, 5'd0);
      step(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
